// File: rtl/qam_symbol_scheduler_if.sv
// qam_symbol_scheduler_if: payload-side and mapper-side handshakes of the QAM symbol scheduler
interface qam_symbol_scheduler_if #(
    parameter int WORD_W = 32,
    parameter int SYM_W  = 4
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic [1:0]        qam;
    logic [SYM_W-1:0]  sym_data;
    logic [2:0]        sym_bps;
    logic [2:0]        sym_sel;
    logic              sym_valid;
    logic              sym_ready;
    logic              sym_last;
    logic              busy;
    logic              error;

    modport master (
        output word_data, word_valid, qam, sym_ready,
        input  word_ready, sym_data, sym_bps, sym_sel, sym_valid, sym_last, busy, error
    );

    modport slave (
        input  word_data, word_valid, qam, sym_ready,
        output word_ready, sym_data, sym_bps, sym_sel, sym_valid, sym_last, busy, error
    );
endinterface

// File: rtl/qam_symbol_scheduler.sv
// qam_symbol_scheduler: slices payload words LSB-first into 1/2/4-bit QAM symbols with back-pressure
module qam_symbol_scheduler #(
    parameter int WORD_W = 32,
    parameter int SYM_W  = 4
) (
    input logic                   clk,
    input logic                   rst,
    qam_symbol_scheduler_if.slave bus
);
    localparam int CW = $clog2(WORD_W);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            r_state, w_state;
    logic [WORD_W-1:0] r_shreg, w_shreg;
    logic [CW-1:0]     r_cnt, w_cnt, w_load_cnt;
    logic [1:0]        r_mode, w_mode, w_qam_mode;
    logic              r_error, w_error;
    logic              w_last, w_acc, w_hs;
    logic [2:0]        w_bps;

    assign w_bps      = r_mode == 2'd2 ? 3'd4 : r_mode == 2'd1 ? 3'd2 : 3'd1;
    assign w_last     = r_state == SEND && r_cnt == '0;
    assign w_acc      = bus.word_valid && bus.word_ready;
    assign w_hs       = r_state == SEND && bus.sym_ready;
    assign w_qam_mode = bus.qam == 2'd3 ? 2'd0 : bus.qam;
    assign w_load_cnt = w_qam_mode == 2'd2 ? CW'(WORD_W / 4 - 1) :
                        w_qam_mode == 2'd1 ? CW'(WORD_W / 2 - 1) : CW'(WORD_W - 1);

    // sym_ready reaches word_ready only; every symbol output comes from registers
    assign bus.word_ready = r_state == IDLE || (w_last && bus.sym_ready);
    assign bus.sym_valid  = r_state == SEND;
    assign bus.busy       = r_state == SEND;
    assign bus.sym_last   = w_last;
    assign bus.sym_bps    = w_bps;
    assign bus.sym_sel    = {r_mode == 2'd2, r_mode == 2'd1, r_mode == 2'd0};
    assign bus.error      = r_error;
    assign bus.sym_data   = r_mode == 2'd2 ? SYM_W'(r_shreg[3:0]) :
                            r_mode == 2'd1 ? SYM_W'(r_shreg[1:0]) : SYM_W'(r_shreg[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_mode  <= 2'd0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state;
            r_shreg <= w_shreg;
            r_cnt   <= w_cnt;
            r_mode  <= w_mode;
            r_error <= w_error;
        end
    end

    // a new word wins over the last-symbol retire, giving zero-bubble back-to-back words
    always_comb begin
        w_state = r_state;
        w_shreg = r_shreg;
        w_cnt   = r_cnt;
        w_mode  = r_mode;
        w_error = r_error | (w_acc && bus.qam == 2'd3);
        if (w_acc) begin
            w_state = SEND;
            w_shreg = bus.word_data;
            w_mode  = w_qam_mode;
            w_cnt   = w_load_cnt;
        end else if (w_hs) begin
            w_state = w_last ? IDLE : SEND;
            w_shreg = r_shreg >> w_bps;
            w_cnt   = w_last ? r_cnt : r_cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// tb_qam_symbol_scheduler: directed and random words checked against a symbol-queue reference model
module tb_qam_symbol_scheduler;
    localparam int WORD_W = 32;
    localparam int SYM_W  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qam_symbol_scheduler_if #(.WORD_W(WORD_W), .SYM_W(SYM_W)) bus ();
    qam_symbol_scheduler #(.WORD_W(WORD_W), .SYM_W(SYM_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_cmp = 0;
    int n_fail = 0;
    int exp_q[$];
    bit last_q[$];
    int m_bps = 1;
    bit m_err = 1'b0;
    bit rnd_rdy = 1'b0;
    bit accepted;
    int hs_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // expected outputs are the head of a queue of every symbol still owed to the mapper
    task automatic cyc();
        bit e_valid, e_ready, e_acc, e_hs;
        int n;
        @(negedge clk);
        e_valid = exp_q.size() > 0;
        e_ready = !e_valid || (exp_q.size() == 1 && bus.sym_ready);
        chk("sym_valid", 32'(bus.sym_valid), 32'(e_valid));
        chk("word_ready", 32'(bus.word_ready), 32'(e_ready));
        chk("busy", 32'(bus.busy), 32'(e_valid));
        chk("error", 32'(bus.error), 32'(m_err));
        chk("sym_bps", 32'(bus.sym_bps), 32'(m_bps));
        chk("sym_sel", 32'(bus.sym_sel), m_bps == 4 ? 32'd4 : m_bps == 2 ? 32'd2 : 32'd1);
        if (e_valid) begin
            chk("sym_data", 32'(bus.sym_data), 32'(exp_q[0]));
            chk("sym_last", 32'(bus.sym_last), 32'(last_q[0]));
        end else chk("sym_last_idle", 32'(bus.sym_last), 32'd0);
        e_acc = bus.word_valid && e_ready;
        e_hs  = e_valid && bus.sym_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            last_q.delete();
            m_bps = 1;
            m_err = 1'b0;
        end else begin
            if (e_hs) begin
                void'(exp_q.pop_front());
                void'(last_q.pop_front());
                hs_cnt++;
            end
            if (e_acc) begin
                accepted = 1'b1;
                m_bps = bus.qam == 2'd2 ? 4 : bus.qam == 2'd1 ? 2 : 1;
                m_err = m_err | (bus.qam == 2'd3);
                n = WORD_W / m_bps;
                for (int k = 0; k < n; k++) begin
                    exp_q.push_back(int'((bus.word_data >> (k * m_bps)) & ((32'd1 << m_bps) - 1)));
                    last_q.push_back(k == n - 1);
                end
            end
        end
        bus.sym_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send(input logic [31:0] w, input logic [1:0] q);
        bus.word_data  = w;
        bus.qam        = q;
        bus.word_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 200 && !accepted; i++) cyc();
        chk("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic drain();
        bus.word_valid = 1'b0;
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
            bus.qam = 2'($urandom);
            cyc();
        end
        chk("drain_timeout", exp_q.size(), 32'd0);
        cyc();
    endtask

    initial begin
        rst            = 1'b1;
        bus.word_valid = 1'b0;
        bus.word_data  = '0;
        bus.qam        = 2'd0;
        bus.sym_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        send(32'hA5A5_0001, 2'd0);
        drain();
        send(32'h7654_3210, 2'd2);
        drain();
        send(32'hFFFF_FFFF, 2'd1);
        send(32'h0000_0000, 2'd1);
        drain();
        rnd_rdy = 1'b1;
        hs_cnt = 0;
        send($urandom, 2'd1);
        drain();
        chk("T5_handshakes", hs_cnt, 32'd16);
        rnd_rdy = 1'b0;
        hs_cnt = 0;
        send($urandom, 2'd3);
        bus.word_valid = 1'b0;
        for (int i = 0; i < 100 && hs_cnt < 5; i++) cyc();
        chk("T6_reach_sym5", hs_cnt, 32'd5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        for (int w = 0; w < 14; w++) begin
            rnd_rdy = 1'($urandom_range(0, 1));
            send($urandom, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) drain();
        end
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
